// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier issuer.
// Contents:
//   FP_WIDTH  - IEEE754 single-precision width.
//   FP_QNAN   - quiet NaN that is reported for an operation that timed out.
//   fp_mul_state_e - issuer FSM states.
//   sat_inc8  - 8-bit saturating increment.
package fp_mul_pkg;

   localparam int FP_WIDTH = 32;
   localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;

   // The ST_ prefix keeps the literals clear of the issuer's GAP parameter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } fp_mul_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fp_mul_rsp_fifo.sv
// Response FIFO for the FP multiplier issuer.
// Synchronous, first-word fall-through: the head entry is visible on 'head'
// whenever 'not_empty' is high. 'head' reads as zero while the FIFO is empty.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset (flushes)
//   push, push_data       - write one entry (ignored when full without a pop)
//   pop                   - drop the head entry (ignored when empty)
//   head, not_empty, count - head entry, occupancy flag and occupancy count
module fp_mul_rsp_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic                       not_empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign not_empty = (count != '0);
   assign do_pop    = pop && not_empty;
   // A simultaneous pop frees the slot the push writes into.
   assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
   assign head      = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_mul_issuer.sv
// Initiator for the in_rdy/res_rdy handshake of an FP multiplier core.
// Takes operand pairs from a request port, issues one multiply at a time,
// holds the operands stable, and queues each result (or a timeout NaN) in a
// response FIFO.
// Handshake rule for req_* and rsp_*: a transfer happens on a rising clk edge
// where valid and ready are both high; ready never depends on valid.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   req_valid/req_ready/req_op1/2   - operand request port
//   rsp_valid/rsp_ready/rsp_res/err - response port (FIFO head)
//   mul_op1/2, mul_in_rdy           - operands and start pulse to the core
//   mul_res, mul_res_rdy            - result and completion strobe from core
//   busy                            - FSM not idle
//   stray_cnt                       - saturating count of unexpected strobes
//   dbg_state                       - current FSM state
module fp_mul_issuer
   import fp_mul_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int GAP     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_op1,
   input  logic [WIDTH-1:0] req_op2,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_res,
   output logic             rsp_err,
   output logic [WIDTH-1:0] mul_op1,
   output logic [WIDTH-1:0] mul_op2,
   output logic             mul_in_rdy,
   input  logic [WIDTH-1:0] mul_res,
   input  logic             mul_res_rdy,
   output logic             busy,
   output logic [7:0]       stray_cnt,
   output fp_mul_state_e    dbg_state
);

   localparam int TW = $clog2(TIMEOUT+1);
   localparam int GW = $clog2(GAP+1);
   localparam int CW = $clog2(DEPTH+1);

   fp_mul_state_e state;
   fp_mul_state_e state_nxt;
   logic [TW-1:0] tcnt;
   logic [GW-1:0] gcnt;
   logic [CW-1:0] fifo_count;
   logic          rst_done;
   logic          push;
   logic          push_err;
   logic [WIDTH:0] push_data;
   logic [WIDTH:0] head;

   // rst_done keeps req_ready low until the first edge after reset release.
   assign req_ready  = rst_done && (state == ST_IDLE) && (fifo_count < CW'(DEPTH));
   assign mul_in_rdy = (state == ST_ISSUE);
   assign busy       = (state != ST_IDLE);
   assign dbg_state  = state;
   assign push_data  = push_err ? {1'b1, WIDTH'(FP_QNAN)} : {1'b0, mul_res};
   assign rsp_err    = head[WIDTH];
   assign rsp_res    = head[WIDTH-1:0];

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_err  = 1'b0;
      case (state)
         ST_IDLE:  if (req_valid && req_ready) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            // A strobe on the timeout cycle still counts as a real result.
            if (mul_res_rdy) begin
               push      = 1'b1;
               state_nxt = ST_GAP;
            end else if (tcnt == TW'(TIMEOUT)) begin
               push      = 1'b1;
               push_err  = 1'b1;
               state_nxt = ST_GAP;
            end
         end
         ST_GAP:   if (gcnt == GW'(GAP)) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         rst_done  <= 1'b0;
         tcnt      <= '0;
         gcnt      <= '0;
         stray_cnt <= '0;
         mul_op1   <= '0;
         mul_op2   <= '0;
      end else begin
         state    <= state_nxt;
         rst_done <= 1'b1;
         if (state == ST_IDLE && state_nxt == ST_ISSUE) begin
            mul_op1 <= req_op1;
            mul_op2 <= req_op2;
         end
         // Both counters start at 1 on the first cycle of their state.
         if (state == ST_ISSUE)     tcnt <= TW'(1);
         else if (state == ST_WAIT) tcnt <= tcnt + 1'b1;
         if (state == ST_WAIT)      gcnt <= GW'(1);
         else if (state == ST_GAP)  gcnt <= gcnt + 1'b1;
         if (mul_res_rdy && state != ST_WAIT) stray_cnt <= sat_inc8(stray_cnt);
      end
   end

   fp_mul_rsp_fifo #(
      .W     (WIDTH+1),
      .DEPTH (DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (rsp_ready),
      .head      (head),
      .not_empty (rsp_valid),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_fp_mul_issuer.sv
module tb_fp_mul_issuer;
   import fp_mul_pkg::*;

   localparam int TIMEOUT = 64;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_op1 = '0;
   logic [31:0] req_op2 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_res;
   logic        rsp_err;
   logic [31:0] mul_op1;
   logic [31:0] mul_op2;
   logic        mul_in_rdy;
   logic [31:0] mul_res = '0;
   logic        mul_res_rdy = 1'b0;
   logic        busy;
   logic [7:0]  stray_cnt;
   fp_mul_state_e dbg_state;

   logic [32:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int stray_exp = 0;

   fp_mul_issuer #(.WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op1(req_op1), .req_op2(req_op2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_err(rsp_err),
      .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_in_rdy(mul_in_rdy),
      .mul_res(mul_res), .mul_res_rdy(mul_res_rdy),
      .busy(busy), .stray_cnt(stray_cnt), .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation through the stub core. res is what the core returns;
   // respond=0 models a core that never strobes. pop_same pops the FIFO
   // head on the same edge as the result push.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                        input bit respond, input logic [31:0] res, input bit pop_same);
      int n;
      logic [32:0] e;
      req_op1 = a;
      req_op2 = b;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk("req_ready_before_accept", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("issue_in_rdy", mul_in_rdy, 1);
      chk("issue_op1", mul_op1, a);
      chk("issue_op2", mul_op2, b);
      chk("issue_req_ready", req_ready, 0);
      tick();
      chk("wait_in_rdy_low", mul_in_rdy, 0);
      if (respond) begin
         for (int i = 0; i < lat; i++) tick();
         chk("wait_still_busy", busy, 1);
         mul_res = res;
         mul_res_rdy = 1'b1;
         if (pop_same && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("same_cycle_head", {rsp_err, rsp_res}, e);
            rsp_ready = 1'b1;
         end
         tick();
         mul_res_rdy = 1'b0;
         rsp_ready = 1'b0;
         exp_q.push_back({1'b0, res});
      end else begin
         for (int i = 0; i < TIMEOUT - 1; i++) tick();
         chk("timeout_not_yet", rsp_valid, exp_q.size() != 0);
         chk("timeout_not_yet_busy", busy, 1);
         tick();
         exp_q.push_back({1'b1, 32'h7FC0_0000});
      end
      chk("gap_busy", busy, 1);
      chk("gap_in_rdy", mul_in_rdy, 0);
      chk("post_push_valid", rsp_valid, 1);
      chk("gap_op1_held", mul_op1, a);
      tick();
      chk("idle_after_gap", busy, 0);
   endtask

   // scoreboard: pop the head and compare with the expected queue
   task automatic pop_one();
      int n;
      logic [32:0] e;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("pop_rsp_valid", rsp_valid, 1);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL pop_queue observed=nonempty expected=empty_model");
      end else begin
         e = exp_q.pop_front();
         chk("rsp_head", {rsp_err, rsp_res}, e);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic strobe_idle(input logic [31:0] v);
      mul_res = v;
      mul_res_rdy = 1'b1;
      tick();
      mul_res_rdy = 1'b0;
      stray_exp = (stray_exp < 255) ? stray_exp + 1 : 255;
   endtask

   initial begin
      logic [31:0] a, b, r;
      bit resp, ps;

      // reset state
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mul_in_rdy", mul_in_rdy, 0);
      chk("rst_mul_op1", mul_op1, 0);
      chk("rst_mul_op2", mul_op2, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stray", stray_cnt, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("release_req_ready_low", req_ready, 0);
      tick();
      chk("release_req_ready_high", req_ready, 1);

      // T1: 2.0 * 3.0
      do_op(32'h4000_0000, 32'h4040_0000, 3, 1'b1, 32'h40C0_0000, 1'b0);
      pop_one();

      // T2: two back-to-back, order kept
      do_op(32'h3F80_0000, 32'hBF80_0000, 2, 1'b1, 32'hBF80_0000, 1'b0);
      do_op(32'h7F80_0000, 32'h0000_0000, 5, 1'b1, 32'hFFC0_0000, 1'b0);
      pop_one();
      pop_one();

      // pop of an empty FIFO is ignored
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("pop_empty_valid", rsp_valid, 0);

      // T3: FIFO fills, fifth request blocked until a pop
      for (int i = 0; i < DEPTH; i++) begin
         r = $urandom;
         do_op($urandom, $urandom, $urandom_range(0, 4), 1'b1, r, 1'b0);
      end
      a = $urandom;
      b = $urandom;
      req_op1 = a;
      req_op2 = b;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("full_req_ready", req_ready, 0);
         chk("full_no_issue", mul_in_rdy, 0);
         tick();
      end
      pop_one();
      chk("after_pop_req_ready", req_ready, 1);
      r = $urandom;
      do_op(a, b, 1, 1'b1, r, 1'b0);
      for (int i = 0; i < DEPTH; i++) pop_one();

      // T4: core never answers -> timeout NaN with err
      do_op(32'h4120_0000, 32'h4130_0000, 0, 1'b0, 32'h0, 1'b0);
      pop_one();

      // result on the exact timeout cycle is a real result
      do_op(32'h3F00_0000, 32'h3F00_0000, TIMEOUT - 1, 1'b1, 32'h3E80_0000, 1'b0);
      pop_one();

      // push and pop on the same edge
      do_op($urandom, $urandom, 2, 1'b1, 32'h1234_5678, 1'b0);
      do_op($urandom, $urandom, 3, 1'b1, 32'h9ABC_DEF0, 1'b1);
      pop_one();

      // T5: strobes while idle are stray, never pushed
      strobe_idle(32'hDEAD_BEEF);
      chk("stray_one", stray_cnt, stray_exp);
      chk("stray_no_rsp", rsp_valid, 0);
      for (int i = 0; i < 260; i++) strobe_idle($urandom);
      chk("stray_saturated", stray_cnt, stray_exp);
      chk("stray_no_rsp_after", rsp_valid, 0);

      // randomized operations against the queue model
      for (int k = 0; k < 16; k++) begin
         if (exp_q.size() >= DEPTH) pop_one();
         resp = ($urandom_range(0, 7) != 0);
         ps = ($urandom_range(0, 2) == 0);
         do_op($urandom, $urandom, $urandom_range(0, 12), resp, $urandom, ps);
         if ($urandom_range(0, 1) == 1) pop_one();
      end
      while (exp_q.size() != 0) pop_one();

      // T6: reset during WAIT with a queued entry
      do_op($urandom, $urandom, 1, 1'b1, $urandom, 1'b0);
      req_op1 = 32'h4080_0000;
      req_op2 = 32'h4080_0000;
      req_valid = 1'b1;
      tick();
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      exp_q.delete();
      stray_exp = 0;
      chk("midrst_in_rdy", mul_in_rdy, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_stray", stray_cnt, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_release_ready_low", req_ready, 0);
      tick();
      do_op(32'h4080_0000, 32'h4080_0000, 4, 1'b1, 32'h4180_0000, 1'b0);
      pop_one();
      chk("final_empty", rsp_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
